// File: rtl/inst_axi_rd_bridge_if.sv
// Bus bundles for the instruction fetch path: the IF-side sram-like fetch port
// and the single-beat AXI read (AR/R) port.
interface inst_sram_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side bridge: turns each accepted IF fetch into one single-beat
// AXI read and returns the responses in order, one data_ok per fetch.
module inst_axi_rd_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    inst_sram_if.slave sram,
    axi_rd_if.master   axi,
    output logic       rd_err
);
    typedef enum logic {AR_IDLE, AR_WAIT} ar_state_e;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    ar_state_e   state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  count_q, count_d;
    logic        rd_err_q, rd_err_d;

    logic accept;
    logic resp;
    logic rready_w;
    logic unused_inputs;

    // One AR in flight at a time; acceptance also gated by the outstanding count.
    assign accept   = (state_q == AR_IDLE) & sram.inst_sram_req & (count_q < MAX_CNT);
    assign rready_w = (count_q != 3'd0);
    assign resp     = axi.rvalid & rready_w & axi.rlast;

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        size_d   = size_q;
        count_d  = count_q;
        rd_err_d = rd_err_q;

        case (state_q)
            AR_IDLE: begin
                if (accept) begin
                    araddr_d = sram.inst_sram_addr;
                    size_d   = sram.inst_sram_size;
                    state_d  = AR_WAIT;
                end
            end
            AR_WAIT: begin
                if (axi.arready) state_d = AR_IDLE;
            end
            default: state_d = AR_IDLE;
        endcase

        case ({accept, resp})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        if (resp && (axi.rresp != 2'b00)) rd_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= AR_IDLE;
            araddr_q <= 32'd0;
            size_q   <= 2'd0;
            count_q  <= 3'd0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            size_q   <= size_d;
            count_q  <= count_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign sram.inst_sram_addr_ok = accept;
    assign sram.inst_sram_data_ok = resp;
    assign sram.inst_sram_rdata   = axi.rdata;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = (state_q == AR_WAIT);
    assign axi.rready  = rready_w;

    assign rd_err = rd_err_q;

    // Write-side fields and rid carry no meaning for instruction reads.
    assign unused_inputs = ^{sram.inst_sram_wr, sram.inst_sram_wstrb,
                             sram.inst_sram_wdata, axi.rid};
endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: scenario tasks plus a scoreboard
// of expected AR requests and returned instructions.
module tb_inst_axi_rd_bridge;
    logic clk = 1'b0;
    logic reset;
    logic rd_err;

    int checks = 0;
    int passed = 0;

    logic [34:0] ar_q[$];
    logic [31:0] d_q[$];

    inst_sram_if sram_if ();
    axi_rd_if    axi_if ();

    inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .AXI_ID(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .sram  (sram_if),
        .axi   (axi_if),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare each AR handshake and each data_ok against queued expectations.
    always @(negedge clk) begin
        if (!reset && axi_if.arvalid && axi_if.arready) begin
            logic [34:0] e;
            checks++;
            if (ar_q.size() == 0) $display("FAIL sb_ar_unexpected: got addr %h, no request expected", axi_if.araddr);
            else begin
                e = ar_q.pop_front();
                if ({axi_if.araddr, axi_if.arsize} !== e)
                    $display("FAIL sb_ar: got addr %h size %0d want addr %h size %0d", axi_if.araddr, axi_if.arsize, e[34:3], e[2:0]);
                else passed++;
            end
        end
        if (!reset && sram_if.inst_sram_data_ok) begin
            logic [31:0] e;
            checks++;
            if (d_q.size() == 0) $display("FAIL sb_data_unexpected: got rdata %h, no response expected", sram_if.inst_sram_rdata);
            else begin
                e = d_q.pop_front();
                if (sram_if.inst_sram_rdata !== e) $display("FAIL sb_data: got %h want %h", sram_if.inst_sram_rdata, e);
                else passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        sram_if.inst_sram_req   = 1'b0;
        sram_if.inst_sram_wr    = 1'b0;
        sram_if.inst_sram_wstrb = 4'h0;
        sram_if.inst_sram_wdata = 32'h0;
        axi_if.rvalid           = 1'b0;
        axi_if.rlast            = 1'b0;
        axi_if.rresp            = 2'b00;
        axi_if.arready          = 1'b1;
    endtask

    task automatic fetch_req(input logic [31:0] a);
        sram_if.inst_sram_req  = 1'b1;
        sram_if.inst_sram_addr = a;
        sram_if.inst_sram_size = 2'd2;
    endtask

    task automatic give_resp(input logic [31:0] d, input logic [1:0] rr);
        axi_if.rvalid = 1'b1;
        axi_if.rlast  = 1'b1;
        axi_if.rdata  = d;
        axi_if.rresp  = rr;
        axi_if.rid    = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (axi_if.arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", axi_if.arvalid); else passed++;
        checks++; if (axi_if.araddr !== 32'd0) $display("FAIL rst_araddr: got %h want 0", axi_if.araddr); else passed++;
        checks++; if (axi_if.arsize !== 3'd0) $display("FAIL rst_arsize: got %0d want 0", axi_if.arsize); else passed++;
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b0) $display("FAIL rst_addr_ok: got %b want 0", sram_if.inst_sram_addr_ok); else passed++;
        checks++; if (sram_if.inst_sram_data_ok !== 1'b0) $display("FAIL rst_data_ok: got %b want 0", sram_if.inst_sram_data_ok); else passed++;
        checks++; if (axi_if.rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", axi_if.rready); else passed++;
        checks++; if (rd_err !== 1'b0) $display("FAIL rst_rd_err: got %b want 0", rd_err); else passed++;
        checks++; if (dut.count_q !== 3'd0) $display("FAIL rst_count: got %0d want 0", dut.count_q); else passed++;
        checks++; if ({axi_if.arid, axi_if.arlen, axi_if.arburst} !== {4'h0, 8'd0, 2'b01})
            $display("FAIL rst_ar_consts: got id %h len %h burst %b want 0/0/01", axi_if.arid, axi_if.arlen, axi_if.arburst); else passed++;
    endtask

    task automatic test_single();
        tick(); fetch_req(32'h1c000000);
        @(negedge clk);
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b1) $display("FAIL single_addr_ok: got %b want 1", sram_if.inst_sram_addr_ok); else passed++;
        ar_q.push_back({32'h1c000000, 3'd2});
        tick();
        @(negedge clk);
        checks++; if (axi_if.arvalid !== 1'b1) $display("FAIL single_arvalid: got %b want 1", axi_if.arvalid); else passed++;
        tick(); give_resp(32'h02800c0c, 2'b00); d_q.push_back(32'h02800c0c);
        @(negedge clk);
        checks++; if (sram_if.inst_sram_data_ok !== 1'b1) $display("FAIL single_data_ok: got %b want 1", sram_if.inst_sram_data_ok); else passed++;
        tick();
        @(negedge clk);
        checks++; if (dut.count_q !== 3'd0) $display("FAIL single_count: got %0d want 0", dut.count_q); else passed++;
    endtask

    task automatic test_ar_backpressure();
        tick(); fetch_req(32'h1c000010); axi_if.arready = 1'b0;
        @(negedge clk);
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b1) $display("FAIL bp_accept: got %b want 1", sram_if.inst_sram_addr_ok); else passed++;
        ar_q.push_back({32'h1c000010, 3'd2});
        for (int i = 1; i <= 3; i++) begin
            tick(); fetch_req(32'h1c000014); axi_if.arready = 1'b0;
            @(negedge clk);
            checks++; if ({axi_if.arvalid, axi_if.araddr} !== {1'b1, 32'h1c000010})
                $display("FAIL bp_hold_c%0d: got arvalid %b addr %h want 1 1c000010", i, axi_if.arvalid, axi_if.araddr); else passed++;
            checks++; if (sram_if.inst_sram_addr_ok !== 1'b0) $display("FAIL bp_addr_ok_c%0d: got %b want 0", i, sram_if.inst_sram_addr_ok); else passed++;
        end
        tick(); fetch_req(32'h1c000014);
        @(negedge clk);
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b0) $display("FAIL bp_addr_ok_c4: got %b want 0", sram_if.inst_sram_addr_ok); else passed++;
        tick(); fetch_req(32'h1c000014);
        @(negedge clk);
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b1) $display("FAIL bp_accept_c5: got %b want 1", sram_if.inst_sram_addr_ok); else passed++;
        ar_q.push_back({32'h1c000014, 3'd2});
        tick();
        tick(); give_resp(32'h0000aaaa, 2'b00); d_q.push_back(32'h0000aaaa);
        tick(); give_resp(32'h0000bbbb, 2'b00); d_q.push_back(32'h0000bbbb);
        tick();
        @(negedge clk);
        checks++; if (axi_if.rready !== 1'b0) $display("FAIL bp_drained_rready: got %b want 0", axi_if.rready); else passed++;
    endtask

    task automatic test_outstanding();
        logic [31:0] a;
        logic        exp_ok;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 32'h1c000000 : (i < 3) ? 32'h1c000004 : 32'h1c000008;
            exp_ok = (i == 0) || (i == 2);
            tick(); fetch_req(a);
            @(negedge clk);
            checks++; if (sram_if.inst_sram_addr_ok !== exp_ok) $display("FAIL out_addr_ok_c%0d: got %b want %b", i, sram_if.inst_sram_addr_ok, exp_ok); else passed++;
            if (exp_ok) ar_q.push_back({a, 3'd2});
        end
        checks++; if (dut.count_q !== 3'd2) $display("FAIL out_count_full: got %0d want 2", dut.count_q); else passed++;
        tick(); fetch_req(32'h1c000008); give_resp(32'h11111111, 2'b00); d_q.push_back(32'h11111111);
        @(negedge clk);
        checks++; if ({sram_if.inst_sram_data_ok, sram_if.inst_sram_addr_ok} !== 2'b10)
            $display("FAIL out_first_ret: got data_ok/addr_ok %b%b want 10", sram_if.inst_sram_data_ok, sram_if.inst_sram_addr_ok); else passed++;
        tick(); fetch_req(32'h1c000008);
        @(negedge clk);
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b1) $display("FAIL out_third_accept: got %b want 1", sram_if.inst_sram_addr_ok); else passed++;
        ar_q.push_back({32'h1c000008, 3'd2});
        tick();
        tick(); give_resp(32'h22222222, 2'b00); d_q.push_back(32'h22222222);
        tick(); give_resp(32'h33333333, 2'b00); d_q.push_back(32'h33333333);
        tick();
        @(negedge clk);
        checks++; if (dut.count_q !== 3'd0) $display("FAIL out_count_drained: got %0d want 0", dut.count_q); else passed++;
    endtask

    task automatic test_simultaneous();
        tick(); fetch_req(32'h1c0000c0); ar_q.push_back({32'h1c0000c0, 3'd2});
        tick();
        tick(); fetch_req(32'h1c0000c4); give_resp(32'h44444444, 2'b00); d_q.push_back(32'h44444444);
        @(negedge clk);
        checks++; if ({sram_if.inst_sram_data_ok, sram_if.inst_sram_addr_ok} !== 2'b11)
            $display("FAIL sim_both: got data_ok/addr_ok %b%b want 11", sram_if.inst_sram_data_ok, sram_if.inst_sram_addr_ok); else passed++;
        ar_q.push_back({32'h1c0000c4, 3'd2});
        tick();
        @(negedge clk);
        checks++; if (dut.count_q !== 3'd1) $display("FAIL sim_count: got %0d want 1", dut.count_q); else passed++;
        tick(); give_resp(32'h55555555, 2'b00); d_q.push_back(32'h55555555);
        tick();
        @(negedge clk);
        checks++; if (dut.count_q !== 3'd0) $display("FAIL sim_count_end: got %0d want 0", dut.count_q); else passed++;
    endtask

    task automatic test_stray_rvalid();
        tick(); give_resp(32'h66666666, 2'b00);
        @(negedge clk);
        checks++; if ({axi_if.rready, sram_if.inst_sram_data_ok} !== 2'b00)
            $display("FAIL stray_resp: got rready/data_ok %b%b want 00", axi_if.rready, sram_if.inst_sram_data_ok); else passed++;
        tick();
        @(negedge clk);
        checks++; if (dut.count_q !== 3'd0) $display("FAIL stray_count: got %0d want 0", dut.count_q); else passed++;
    endtask

    task automatic test_error();
        tick(); fetch_req(32'h1c000100); ar_q.push_back({32'h1c000100, 3'd2});
        tick();
        tick(); give_resp(32'hdeadbeef, 2'b10); d_q.push_back(32'hdeadbeef);
        @(negedge clk);
        checks++; if (sram_if.inst_sram_data_ok !== 1'b1) $display("FAIL err_data_ok: got %b want 1", sram_if.inst_sram_data_ok); else passed++;
        tick();
        @(negedge clk);
        checks++; if (rd_err !== 1'b1) $display("FAIL err_set: got %b want 1", rd_err); else passed++;
        // Clean read issued with the write flag set must still behave as a read.
        tick(); fetch_req(32'h1c000104); sram_if.inst_sram_wr = 1'b1; sram_if.inst_sram_wstrb = 4'hf;
        sram_if.inst_sram_wdata = $urandom; ar_q.push_back({32'h1c000104, 3'd2});
        @(negedge clk);
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b1) $display("FAIL err_wr_accept: got %b want 1", sram_if.inst_sram_addr_ok); else passed++;
        tick();
        tick(); give_resp(32'h77777777, 2'b00); d_q.push_back(32'h77777777);
        tick();
        @(negedge clk);
        checks++; if (rd_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", rd_err); else passed++;
    endtask

    task automatic test_reset_midflight();
        tick(); fetch_req(32'h1c000200); ar_q.push_back({32'h1c000200, 3'd2});
        tick();
        tick(); fetch_req(32'h1c000204); axi_if.arready = 1'b0;
        tick(); axi_if.arready = 1'b0; reset = 1'b1;
        @(negedge clk);
        checks++; if ({axi_if.arvalid, dut.count_q} !== {1'b1, 3'd2})
            $display("FAIL mid_pre: got arvalid %b count %0d want 1 2", axi_if.arvalid, dut.count_q); else passed++;
        ar_q.delete();
        d_q.delete();
        tick(); reset = 1'b0;
        @(negedge clk);
        checks++; if ({axi_if.arvalid, dut.count_q, axi_if.rready} !== {1'b0, 3'd0, 1'b0})
            $display("FAIL mid_cleared: got arvalid %b count %0d rready %b want 0 0 0", axi_if.arvalid, dut.count_q, axi_if.rready); else passed++;
        tick(); fetch_req(32'h1c000300);
        @(negedge clk);
        checks++; if (sram_if.inst_sram_addr_ok !== 1'b1) $display("FAIL mid_new_accept: got %b want 1", sram_if.inst_sram_addr_ok); else passed++;
        ar_q.push_back({32'h1c000300, 3'd2});
        tick();
        tick(); give_resp(32'h88888888, 2'b00); d_q.push_back(32'h88888888);
        tick();
        @(negedge clk);
        checks++; if (rd_err !== 1'b0) $display("FAIL mid_rd_err_cleared: got %b want 0", rd_err); else passed++;
    endtask

    initial begin
        reset                   = 1'b1;
        sram_if.inst_sram_req   = 1'b0;
        sram_if.inst_sram_wr    = 1'b0;
        sram_if.inst_sram_size  = 2'd0;
        sram_if.inst_sram_wstrb = 4'h0;
        sram_if.inst_sram_addr  = 32'h0;
        sram_if.inst_sram_wdata = 32'h0;
        axi_if.arready          = 1'b1;
        axi_if.rid              = 4'h0;
        axi_if.rdata            = 32'h0;
        axi_if.rresp            = 2'b00;
        axi_if.rlast            = 1'b0;
        axi_if.rvalid           = 1'b0;

        test_reset();
        test_single();
        test_ar_backpressure();
        test_outstanding();
        test_simultaneous();
        test_stray_rvalid();
        test_error();
        test_reset_midflight();

        tick();
        @(negedge clk);
        checks++; if (ar_q.size() != 0) $display("FAIL sb_ar_leftover: got %0d pending want 0", ar_q.size()); else passed++;
        checks++; if (d_q.size() != 0) $display("FAIL sb_data_leftover: got %0d pending want 0", d_q.size()); else passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
